// File: rtl/riscv_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the RV32 datapath/data memory.
// master = controller side, slave = datapath/memory side.
interface riscv_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             mem_ack;

  logic             branch;
  logic             jump;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             alu_src;
  logic             reg_write;
  logic [3:0]       alu_op;
  logic             pc_en;
  logic             mem_req;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retire_count;

  modport master (
    input  run, opcode, funct3, funct7, mem_ack,
    output branch, jump, mem_read, mem_write, mem_to_reg, alu_src, reg_write,
           alu_op, pc_en, mem_req, trap, trap_cause, retire_count
  );

  modport slave (
    output run, opcode, funct3, funct7, mem_ack,
    input  branch, jump, mem_read, mem_write, mem_to_reg, alu_src, reg_write,
           alu_op, pc_en, mem_req, trap, trap_cause, retire_count
  );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: FETCH->DECODE->EXEC->[MEM]->WB with a timed
// data-memory handshake, sticky trap reporting and a retired-instruction counter.
module riscv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                     clk,
  input logic                     rst,
  riscv_multicycle_ctrl_if.master ctrl_io
);

  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;
  typedef enum logic [2:0] {K_R, K_I, K_LW, K_SW, K_BEQ, K_JALR} kind_e;

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic [3:0]         aluOp_q, aluOp_d;
  logic [WCNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   retire_q, retire_d;

  logic               decLegal;
  kind_e              decKind;
  logic [3:0]         decAluOp;
  logic               srcImm;

  // alt selects SUB/SRA over ADD/SRL on the two funct3 codes that share an encoding
  function automatic logic [3:0] aluFromF3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    decLegal = 1'b0;
    decKind  = K_R;
    decAluOp = ALU_ADD;
    case (ctrl_io.opcode)
      OP_R: begin
        decKind  = K_R;
        decLegal = (ctrl_io.funct7 == 7'b0000000) ||
                   ((ctrl_io.funct7 == F7_ALT) &&
                    ((ctrl_io.funct3 == 3'b000) || (ctrl_io.funct3 == 3'b101)));
        decAluOp = aluFromF3(ctrl_io.funct3, ctrl_io.funct7 == F7_ALT);
      end
      OP_I: begin
        // funct7 is immediate bits here, so only SRAI honours the alternate encoding
        decKind  = K_I;
        decLegal = 1'b1;
        decAluOp = aluFromF3(ctrl_io.funct3,
                             (ctrl_io.funct3 == 3'b101) && (ctrl_io.funct7 == F7_ALT));
      end
      OP_LW: begin
        decKind  = K_LW;
        decLegal = (ctrl_io.funct3 == 3'b010);
      end
      OP_SW: begin
        decKind  = K_SW;
        decLegal = (ctrl_io.funct3 == 3'b010);
      end
      OP_BEQ: begin
        decKind  = K_BEQ;
        decLegal = (ctrl_io.funct3 == 3'b000);
        decAluOp = ALU_SUB;
      end
      OP_JALR: begin
        decKind  = K_JALR;
        decLegal = (ctrl_io.funct3 == 3'b000);
      end
      default: decLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      kind_q    <= K_R;
      aluOp_q   <= ALU_ADD;
      waitCnt_q <= '0;
      cause_q   <= 2'b00;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      aluOp_q   <= aluOp_d;
      waitCnt_q <= waitCnt_d;
      cause_q   <= cause_d;
      retire_q  <= retire_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    aluOp_d   = aluOp_q;
    waitCnt_d = waitCnt_q;
    cause_d   = cause_q;
    retire_d  = retire_q;
    case (state_q)
      FETCH: begin
        if (ctrl_io.run) state_d = DECODE;
      end
      DECODE: begin
        if (decLegal) begin
          state_d = EXEC;
          kind_d  = decKind;
          aluOp_d = decAluOp;
        end else begin
          state_d = TRAP;
          cause_d = 2'b01;
        end
      end
      EXEC: begin
        if ((kind_q == K_LW) || (kind_q == K_SW)) begin
          state_d   = MEM;
          waitCnt_d = '0;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        // an ack on the final allowed cycle still completes the access
        if (ctrl_io.mem_ack) begin
          state_d = WB;
        end else if (waitCnt_q == WAIT_LAST) begin
          state_d = TRAP;
          cause_d = 2'b10;
        end else begin
          waitCnt_d = waitCnt_q + WCNT_W'(1);
        end
      end
      WB: begin
        retire_d = retire_q + CNT_W'(1);
        state_d  = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  assign srcImm = (kind_q == K_I) || (kind_q == K_LW) || (kind_q == K_SW) || (kind_q == K_JALR);

  always_comb begin
    ctrl_io.branch     = 1'b0;
    ctrl_io.jump       = 1'b0;
    ctrl_io.mem_read   = 1'b0;
    ctrl_io.mem_write  = 1'b0;
    ctrl_io.mem_to_reg = 1'b0;
    ctrl_io.alu_src    = 1'b0;
    ctrl_io.reg_write  = 1'b0;
    ctrl_io.alu_op     = ALU_ADD;
    ctrl_io.pc_en      = 1'b0;
    ctrl_io.mem_req    = 1'b0;
    ctrl_io.trap       = 1'b0;
    case (state_q)
      EXEC: begin
        ctrl_io.alu_op  = aluOp_q;
        ctrl_io.alu_src = srcImm;
        ctrl_io.branch  = (kind_q == K_BEQ);
        ctrl_io.jump    = (kind_q == K_JALR);
      end
      MEM: begin
        ctrl_io.alu_op     = aluOp_q;
        ctrl_io.alu_src    = srcImm;
        ctrl_io.mem_req    = 1'b1;
        ctrl_io.mem_read   = (kind_q == K_LW);
        ctrl_io.mem_write  = (kind_q == K_SW);
        ctrl_io.mem_to_reg = (kind_q == K_LW);
      end
      WB: begin
        ctrl_io.alu_op     = aluOp_q;
        ctrl_io.alu_src    = srcImm;
        ctrl_io.branch     = (kind_q == K_BEQ);
        ctrl_io.jump       = (kind_q == K_JALR);
        ctrl_io.mem_to_reg = (kind_q == K_LW);
        ctrl_io.reg_write  = (kind_q == K_R) || (kind_q == K_I) || (kind_q == K_LW);
        ctrl_io.pc_en      = 1'b1;
      end
      TRAP:    ctrl_io.trap = 1'b1;
      default: ctrl_io.trap = 1'b0;
    endcase
  end

  assign ctrl_io.trap_cause   = cause_q;
  assign ctrl_io.retire_count = retire_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized self-checking bench for riscv_multicycle_ctrl; a transaction-level
// model predicts every cycle's control vector from the instruction and ack latency.
module tb_riscv_multicycle_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 16;
  localparam int NO_ACK      = 99;

  localparam logic [3:0] R_OP [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
  localparam logic [6:0] OPS  [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                      7'b0100011, 7'b1100011, 7'b1100111};

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   retired    = 0;

  riscv_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] obsVec;
  assign obsVec = {bus.branch, bus.jump, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                   bus.alu_src, bus.reg_write, bus.alu_op, bus.pc_en, bus.mem_req,
                   bus.trap, bus.trap_cause};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] vec(input bit br, input bit jp, input bit mr, input bit mw,
                                      input bit mtr, input bit src, input bit rw,
                                      input logic [3:0] op, input bit pc, input bit req,
                                      input bit trp, input logic [1:0] cause);
    return {br, jp, mr, mw, mtr, src, rw, op, pc, req, trp, cause};
  endfunction

  // kind: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 BEQ, 5 JALR
  function automatic void decodeRef(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, output bit legal,
                                    output int kind, output logic [3:0] aop);
    legal = 1'b0; kind = -1; aop = 4'd0;
    if (op == OPS[0]) begin
      kind  = 0;
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      aop   = R_OP[f3];
      if (f7 == 7'h20 && f3 == 3'd0) aop = 4'd1;
      if (f7 == 7'h20 && f3 == 3'd5) aop = 4'd7;
    end else if (op == OPS[1]) begin
      kind = 1; legal = 1'b1; aop = R_OP[f3];
      if (f3 == 3'd5 && f7 == 7'h20) aop = 4'd7;
    end else if (op == OPS[2]) begin
      kind = 2; legal = (f3 == 3'd2);
    end else if (op == OPS[3]) begin
      kind = 3; legal = (f3 == 3'd2);
    end else if (op == OPS[4]) begin
      kind = 4; legal = (f3 == 3'd0); aop = 4'd1;
    end else if (op == OPS[5]) begin
      kind = 5; legal = (f3 == 3'd0);
    end
  endfunction

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic run);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.run    = run;
  endtask

  // Entered and left at posedge+1; outputs are sampled on the falling edge.
  task automatic clockCycle(input string tag, input logic [15:0] exp);
    @(negedge clk);
    checkOutput(tag, {16'd0, obsVec}, {16'd0, exp});
    checkOutput("retire", 32'(bus.retire_count), 32'(retired % (1 << CNT_W)));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.mem_ack = 1'b0;
    bus.run = 1'b0;
    retired = 0;
    #2;
    checkOutput("rst_ctl", {16'd0, obsVec}, 32'd0);
    checkOutput("rst_cnt", 32'(bus.retire_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input int ackLat, input int idle, input int rstAt,
                          output bit stopped);
    bit legal, br, jp, isLw, isSw, imm, rw, gotAck;
    int kind;
    logic [3:0] aop;
    decodeRef(op, f3, f7, legal, kind, aop);
    br   = (kind == 4);
    jp   = (kind == 5);
    isLw = (kind == 2);
    isSw = (kind == 3);
    imm  = (kind == 1) || isLw || isSw || jp;
    rw   = (kind == 0) || (kind == 1) || isLw;
    stopped = 1'b1;
    gotAck  = 1'b0;

    applyStimulus(op, f3, f7, 1'b0);
    repeat (idle) clockCycle("idle", 16'd0);
    bus.run = 1'b1;
    clockCycle("fetch", 16'd0);
    bus.run = 1'($urandom_range(0, 1));
    clockCycle("decode", 16'd0);
    if (!legal) begin
      repeat (3) clockCycle("trap_illegal", vec(0,0,0,0,0,0,0,4'd0,0,0,1,2'b01));
      return;
    end
    clockCycle("exec", vec(br,jp,0,0,0,imm,0,aop,0,0,0,2'b00));
    if (isLw || isSw) begin
      for (int k = 0; k < MEM_TIMEOUT; k++) begin
        if (k == rstAt) begin
          bus.mem_ack = 1'b0;
          #2 rst = 1'b1;
          retired = 0;
          #1;
          checkOutput("rst_in_mem", {16'd0, obsVec}, 32'd0);
          @(posedge clk);
          #1;
          bus.run = 1'b0;
          rst = 1'b0;
          clockCycle("after_rst", 16'd0);
          return;
        end
        bus.mem_ack = (k == ackLat);
        clockCycle("mem", vec(0,0,isLw,isSw,isLw,1,0,aop,0,1,0,2'b00));
        bus.mem_ack = 1'b0;
        if (k == ackLat) begin
          gotAck = 1'b1;
          break;
        end
      end
      if (!gotAck) begin
        repeat (3) clockCycle("trap_timeout", vec(0,0,0,0,0,0,0,4'd0,0,0,1,2'b10));
        return;
      end
    end
    clockCycle("wb", vec(br,jp,0,0,isLw,imm,rw,aop,1,0,0,2'b00));
    retired++;
    stopped = 1'b0;
  endtask

  task automatic randInstr(input bit legalOnly, output logic [6:0] op,
                           output logic [2:0] f3, output logic [6:0] f7);
    int sel;
    sel = legalOnly ? $urandom_range(0, 5) : $urandom_range(0, 6);
    op  = (sel == 6) ? 7'($urandom) : OPS[sel];
    f3  = 3'($urandom);
    f7  = 7'h00;
    if (sel == 2 || sel == 3) begin
      if (legalOnly || $urandom_range(0, 3) != 0) f3 = 3'd2;
    end else if (sel == 4 || sel == 5) begin
      if (legalOnly || $urandom_range(0, 3) != 0) f3 = 3'd0;
    end
    if (legalOnly) begin
      if ((sel == 0 || sel == 1) && (f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
        f7 = 7'h20;
      if (sel == 1 && f3 != 3'd5) f7 = 7'($urandom);
    end else begin
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
    end
  endtask

  initial begin
    bit stopped;
    logic [6:0] op, f7;
    logic [2:0] f3;
    int lat;

    rst = 1'b1;
    bus.mem_ack = 1'b0;
    applyStimulus(7'd0, 3'd0, 7'd0, 1'b0);
    #2;
    checkOutput("reset_ctl", {16'd0, obsVec}, 32'd0);
    checkOutput("reset_cnt", 32'(bus.retire_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    runInstr(7'b0110011, 3'b000, 7'b0100000, NO_ACK, 0, -1, stopped);
    runInstr(7'b0000011, 3'b010, 7'b0000000, 3, 0, -1, stopped);
    runInstr(7'b1100011, 3'b000, 7'b0000000, NO_ACK, 0, -1, stopped);
    runInstr(7'b1100111, 3'b000, 7'b0000000, NO_ACK, 0, -1, stopped);
    runInstr(7'b0010011, 3'b101, 7'b0100000, NO_ACK, 4, -1, stopped);
    runInstr(7'b0100011, 3'b010, 7'b0000000, MEM_TIMEOUT - 1, 0, -1, stopped);
    for (int i = 0; i < 14; i++) begin
      randInstr(1'b1, op, f3, f7);
      runInstr(op, f3, f7, $urandom_range(0, 4), $urandom_range(0, 2), -1, stopped);
    end

    runInstr(7'b0100011, 3'b010, 7'b0000000, NO_ACK, 0, -1, stopped);
    checkOutput("sw_timeout_trapped", 32'(stopped), 32'd1);
    doReset();
    runInstr(7'b0110011, 3'b000, 7'b0000000, NO_ACK, 0, -1, stopped);
    runInstr(7'b1101111, 3'b000, 7'b0000000, NO_ACK, 0, -1, stopped);
    checkOutput("jal_trapped", 32'(stopped), 32'd1);
    doReset();
    runInstr(7'b0000011, 3'b010, 7'b0000000, NO_ACK, 0, 2, stopped);

    for (int i = 0; i < 60; i++) begin
      randInstr(1'b0, op, f3, f7);
      lat = ($urandom_range(0, 7) == 0) ? NO_ACK : $urandom_range(0, 5);
      runInstr(op, f3, f7, lat, $urandom_range(0, 2),
               ($urandom_range(0, 15) == 0) ? $urandom_range(0, 3) : -1, stopped);
      if (stopped) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
